// File: rtl/mc_control.sv
// Multicycle MIPS-style control unit: state sequencing, per-state control
// decode, and a memory wait-state watchdog that traps into a sticky ERROR state.
module mc_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       ir_write,
   output logic       iord,
   output logic       mem_req,
   output logic       mem_we,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic       ext_op,
   output logic       lui_en,
   output logic       branch_ne,
   output logic [1:0] pc_src,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic       halted,
   output logic [1:0] err_code,
   output logic [3:0] state_o
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEM_ADDR = 4'd2;
   localparam logic [3:0] S_MEM_RD   = 4'd3;
   localparam logic [3:0] S_MEM_WB   = 4'd4;
   localparam logic [3:0] S_MEM_WR   = 4'd5;
   localparam logic [3:0] S_EXEC_R   = 4'd6;
   localparam logic [3:0] S_ALU_WB   = 4'd7;
   localparam logic [3:0] S_EXEC_I   = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JUMP     = 4'd10;
   localparam logic [3:0] S_JR       = 4'd11;
   localparam logic [3:0] S_ERROR    = 4'd15;

   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       err_q, err_d;
   logic             timeout;
   logic             wait_state;
   logic             ready_m;
   logic             unused_zero;

   // The branch decision (zero XOR branch_ne) is made in the datapath.
   assign unused_zero = zero;

   assign timeout    = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LIMIT) && !mem_ready;
   assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready)    state_d = S_DECODE;
            else if (timeout) begin state_d = S_ERROR; err_d = 2'b10; end
         end
         S_DECODE: begin
            case (opcode)
               6'h00:                      state_d = (funct == 6'h08) ? S_JR : S_EXEC_R;
               6'h23, 6'h2B:               state_d = S_MEM_ADDR;
               6'h08, 6'h0A, 6'h0B, 6'h0C,
               6'h0D, 6'h0E, 6'h0F:        state_d = S_EXEC_I;
               6'h04, 6'h05:               state_d = S_BRANCH;
               6'h02, 6'h03:               state_d = S_JUMP;
               default: begin state_d = S_ERROR; err_d = 2'b01; end
            endcase
         end
         S_MEM_ADDR: state_d = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: begin
            if (mem_ready)    state_d = S_MEM_WB;
            else if (timeout) begin state_d = S_ERROR; err_d = 2'b10; end
         end
         S_MEM_WR: begin
            if (mem_ready)    state_d = S_FETCH;
            else if (timeout) begin state_d = S_ERROR; err_d = 2'b10; end
         end
         S_EXEC_R, S_EXEC_I:                      state_d = S_ALU_WB;
         S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_JR: state_d = S_FETCH;
         S_ERROR:                                 state_d = S_ERROR;
         default:                                 state_d = S_FETCH;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q)
         cnt_d = '0;
      else if (wait_state && !mem_ready && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // While in reset the FETCH decode is shown but must not strobe IR/PC.
   assign ready_m = mem_ready & rst_n;

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      iord          = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      ext_op        = 1'b1;
      lui_en        = 1'b0;
      branch_ne     = 1'b0;
      pc_src        = 2'b00;
      reg_dst       = 2'b00;
      mem_to_reg    = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 3'b000;
      halted        = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = ready_m;
            pc_write  = ready_m;
         end
         S_DECODE:   alu_src_b = 2'b11;
         S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
         S_MEM_RD:   begin mem_req = 1'b1; iord = 1'b1; end
         S_MEM_WB:   begin reg_write = 1'b1; mem_to_reg = 2'b01; end
         S_MEM_WR:   begin mem_req = 1'b1; iord = 1'b1; mem_we = ready_m; end
         S_EXEC_R:   begin alu_src_a = 1'b1; alu_op = 3'b010; end
         S_ALU_WB: begin
            reg_write = 1'b1;
            reg_dst   = (opcode == 6'h00) ? 2'b01 : 2'b00;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            case (opcode)
               6'h0A:               alu_op = 3'b100;
               6'h0B:               alu_op = 3'b101;
               6'h0C, 6'h0D, 6'h0E: begin alu_op = 3'b011; ext_op = 1'b0; end
               6'h0F:               begin lui_en = 1'b1; ext_op = 1'b0; end
               default:             alu_op = 3'b000;
            endcase
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 3'b001;
            pc_write_cond = 1'b1;
            pc_src        = 2'b01;
            branch_ne     = (opcode == 6'h05);
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            if (opcode == 6'h03) begin
               reg_write  = 1'b1;
               reg_dst    = 2'b10;
               mem_to_reg = 2'b10;
            end
         end
         S_JR:    begin pc_write = 1'b1; pc_src = 2'b11; end
         S_ERROR: halted = 1'b1;
         default: ;
      endcase
   end

   assign err_code = err_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios plus random instruction
// streams checked cycle by cycle against an instruction-level reference model.
module tb_mc_control;

   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'h00;
   logic [5:0] funct = 6'h00;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       pc_write, pc_write_cond, ir_write, iord, mem_req, mem_we, reg_write;
   logic       alu_src_a, ext_op, lui_en, branch_ne, halted;
   logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, err_code;
   logic [2:0] alu_op;
   logic [3:0] state_o;
   logic [28:0] obsVec;

   int checks = 0;
   int errors = 0;
   logic [1:0] modelErr = 2'b00;

   mc_control #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .ir_write(ir_write), .iord(iord), .mem_req(mem_req), .mem_we(mem_we),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .ext_op(ext_op), .lui_en(lui_en),
      .branch_ne(branch_ne), .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .halted(halted), .err_code(err_code),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   assign obsVec = {state_o, mem_req, iord, mem_we, ir_write, pc_write, pc_write_cond,
                    reg_write, alu_src_a, ext_op, lui_en, branch_ne, halted,
                    pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op, err_code};

   // Expected control word for a named state, straight from the per-state tables.
   function automatic logic [28:0] expOut(int st, logic [5:0] op, logic rdy, logic [1:0] err);
      logic mreq = 0, io = 0, we = 0, irw = 0, pcw = 0, pcc = 0, rw = 0, asa = 0;
      logic ext = 1, lui = 0, bne = 0, hlt = 0;
      logic [1:0] psrc = 0, rdst = 0, m2r = 0, asb = 0;
      logic [2:0] aop = 0;
      case (st)
         0:  begin mreq = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mreq = 1; io = 1; end
         4:  begin rw = 1; m2r = 2'b01; end
         5:  begin mreq = 1; io = 1; we = rdy; end
         6:  begin asa = 1; aop = 3'b010; end
         7:  begin rw = 1; rdst = (op == 6'h00) ? 2'b01 : 2'b00; end
         8: begin
            asa = 1; asb = 2'b10;
            if (op == 6'h0A) aop = 3'b100;
            if (op == 6'h0B) aop = 3'b101;
            if (op == 6'h0C || op == 6'h0D || op == 6'h0E) begin aop = 3'b011; ext = 0; end
            if (op == 6'h0F) begin lui = 1; ext = 0; end
         end
         9:  begin asa = 1; aop = 3'b001; pcc = 1; psrc = 2'b01; bne = (op == 6'h05); end
         10: begin
            pcw = 1; psrc = 2'b10;
            if (op == 6'h03) begin rw = 1; rdst = 2'b10; m2r = 2'b10; end
         end
         11: begin pcw = 1; psrc = 2'b11; end
         15: hlt = 1;
         default: ;
      endcase
      return {st[3:0], mreq, io, we, irw, pcw, pcc, rw, asa, ext, lui, bne, hlt,
              psrc, rdst, m2r, asb, aop, err};
   endfunction

   task automatic checkOutput(string tag, logic [28:0] obs, logic [28:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive mem_ready at the falling edge, check, then cross the rising edge.
   task automatic applyStimulus(int st, logic rdy);
      @(negedge clk);
      mem_ready = rdy;
      #1 checkOutput($sformatf("trace_op%0h_st%0d", opcode, st), obsVec,
                     expOut(st, opcode, rdy, (st == 15) ? modelErr : 2'b00));
      @(posedge clk);
   endtask

   task automatic doReset();
      #2 rst_n = 1'b0;
      mem_ready = 1'b1;
      modelErr = 2'b00;
      #1 checkOutput("reset_async", obsVec, expOut(0, opcode, 1'b0, 2'b00));
      @(posedge clk);
      #1 checkOutput("reset_held", obsVec, expOut(0, opcode, 1'b0, 2'b00));
      #1 rst_n = 1'b1;
   endtask

   // A memory wait phase: w not-ready cycles, then ready, unless the watchdog fires first.
   task automatic waitPhase(int st, int w, output bit ok);
      ok = 1'b0;
      for (int i = 0; ; i++) begin
         applyStimulus(st, (i == w));
         if (i == w) begin ok = 1'b1; return; end
         if (i == TIMEOUT) begin modelErr = 2'b10; return; end
      end
   endtask

   task automatic errorTail();
      repeat (2) applyStimulus(15, 1'($urandom_range(0, 1)));
      doReset();
   endtask

   task automatic runInstr(logic [5:0] op, logic [5:0] fn, int fw, int mw);
      bit ok;
      opcode = op;
      funct  = fn;
      waitPhase(0, fw, ok);
      if (!ok) begin errorTail(); return; end
      applyStimulus(1, 1'($urandom_range(0, 1)));
      case (op)
         6'h23: begin
            applyStimulus(2, 1'($urandom_range(0, 1)));
            waitPhase(3, mw, ok);
            if (!ok) begin errorTail(); return; end
            applyStimulus(4, 1'($urandom_range(0, 1)));
         end
         6'h2B: begin
            applyStimulus(2, 1'($urandom_range(0, 1)));
            waitPhase(5, mw, ok);
            if (!ok) begin errorTail(); return; end
         end
         6'h00: begin
            if (fn == 6'h08) applyStimulus(11, 1'($urandom_range(0, 1)));
            else begin
               applyStimulus(6, 1'($urandom_range(0, 1)));
               applyStimulus(7, 1'($urandom_range(0, 1)));
            end
         end
         6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            applyStimulus(8, 1'($urandom_range(0, 1)));
            applyStimulus(7, 1'($urandom_range(0, 1)));
         end
         6'h04, 6'h05: applyStimulus(9, 1'($urandom_range(0, 1)));
         6'h02, 6'h03: applyStimulus(10, 1'($urandom_range(0, 1)));
         default: begin modelErr = 2'b01; errorTail(); end
      endcase
   endtask

   function automatic int pickWait();
      if ($urandom_range(0, 9) == 0) return int'($urandom_range(TIMEOUT, TIMEOUT + 4));
      return int'($urandom_range(0, 3));
   endfunction

   initial begin
      logic [5:0] legal [15];
      logic [5:0] illegal [6];
      legal   = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0A, 6'h0B, 6'h0C,
                  6'h0D, 6'h0E, 6'h0F, 6'h04, 6'h05, 6'h02, 6'h03};
      illegal = '{6'h01, 6'h06, 6'h09, 6'h10, 6'h20, 6'h3F};

      doReset();
      runInstr(6'h23, 6'h00, 0, 0);          // lw, no waits
      runInstr(6'h20 ^ 6'h20, 6'h20, 3, 0);  // R-type add behind a 3-cycle fetch stall
      runInstr(6'h03, 6'h00, 0, 0);          // jal
      runInstr(6'h2B, 6'h00, 0, 40);         // sw with memory stuck: watchdog trap
      runInstr(6'h3F, 6'h00, 0, 0);          // illegal opcode
      runInstr(6'h05, 6'h00, 0, 0);          // bne
      runInstr(6'h00, 6'h08, 0, 0);          // jr
      runInstr(6'h23, 6'h00, TIMEOUT, TIMEOUT); // ready exactly at the limit
      runInstr(6'h0F, 6'h00, 0, 0);          // lui
      runInstr(6'h00, 6'h00, TIMEOUT + 1, 0);   // fetch timeout

      // Abort an in-flight lw with an asynchronous reset.
      opcode = 6'h23;
      applyStimulus(0, 1'b1);
      applyStimulus(1, 1'b0);
      applyStimulus(2, 1'b1);
      applyStimulus(3, 1'b0);
      doReset();

      for (int n = 0; n < 60; n++) begin
         logic [5:0] op;
         logic [5:0] fn;
         if ($urandom_range(0, 11) == 0) op = illegal[$urandom_range(0, 5)];
         else op = legal[$urandom_range(0, 14)];
         fn = 6'($urandom_range(0, 63));
         if (op == 6'h00 && $urandom_range(0, 3) == 0) fn = 6'h08;
         zero = 1'($urandom_range(0, 1));
         runInstr(op, fn, pickWait(), pickWait());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
